// File: rtl/jk_stim_checker.sv
// Self-test driver and checker for a clocked JK flip-flop: drives {en,j,k}, tracks a golden q, counts bad vectors.
// Optional JKC_LFSR_EN: vectors come from an 8-bit LFSR seeded with SEED instead of the counting pattern.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start
// INIT      | en=1 j=0 k=1 forces the flip-flop to 0
// INIT_WAIT | settle after init, drive idle
// DRIVE     | vector v on {en,j,k}; golden model updates on exit
// WAIT      | settle, drive idle so toggles act once
// CHECK     | compare q/q_bar with golden state, advance or finish
// DONE      | results held until next start
module jk_stim_checker #(
   parameter int         NUM_VEC    = 8,
   parameter int         SETTLE_CYC = 1,
   parameter logic [7:0] SEED       = 8'hA5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         q,
   input  logic                         q_bar,
   output logic                         j,
   output logic                         k,
   output logic                         en,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic [$clog2(NUM_VEC+1)-1:0] err_count,
   output logic [$clog2(NUM_VEC)-1:0]   fail_idx
);

   localparam int EW = $clog2(NUM_VEC + 1);
   localparam int VW = $clog2(NUM_VEC);
   localparam logic [EW-1:0] ERR_MAX     = EW'(NUM_VEC);
   localparam logic [VW-1:0] V_LAST      = VW'(NUM_VEC - 1);
   localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE_CYC - 1);

   if (NUM_VEC < 2 || NUM_VEC > 256 || SETTLE_CYC < 1 || SETTLE_CYC > 15 || SEED == 8'h00)
   begin : g_bad_param
      $error("jk_stim_checker: parameter out of range");
   end

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      INIT_WAIT,
      DRIVE,
      WAIT,
      CHECK,
      DONE
   } state_t;

   state_t        state;
   logic [VW-1:0] v;
   logic [3:0]    settle_cnt;
   logic          exp_q;
   logic          exp_next;
   logic          mismatch;
   logic [EW-1:0] err_inc;
   logic [2:0]    drive_vec;
   logic          start_ok;

   assign start_ok = start && (state == IDLE || state == DONE);

`ifdef JKC_LFSR_EN
   logic [7:0] lfsr;
   logic       lfsr_fb;

   assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   assign drive_vec = lfsr[2:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= SEED;
      end else if (start_ok) begin
         lfsr <= SEED;
      end else if (state == DRIVE) begin
         lfsr <= {lfsr[6:0], lfsr_fb};
      end
   end
`else
   logic [VW-1:0] v_drive;
   logic [2:0]    pat;

   // Leaving CHECK the next vector is v+1, so the registered drive must look ahead.
   assign v_drive   = (state == CHECK) ? v + VW'(1) : v;
   assign pat       = 3'(v_drive);
   assign drive_vec = {~pat[2], pat[1], pat[0]};
`endif

   always_comb begin
      exp_next = exp_q;
      if (en) begin
         case ({j, k})
            2'b01:   exp_next = 1'b0;
            2'b10:   exp_next = 1'b1;
            2'b11:   exp_next = ~exp_q;
            default: exp_next = exp_q;
         endcase
      end
   end

`ifdef SYNTHESIS
   assign mismatch = (q != exp_q) || (q_bar != ~exp_q);
`else
   assign mismatch = (q !== exp_q) || (q_bar !== ~exp_q);
`endif

   assign err_inc = (mismatch && err_count != ERR_MAX) ? err_count + EW'(1) : err_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         j          <= 1'b0;
         k          <= 1'b0;
         en         <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_idx   <= '0;
         exp_q      <= 1'b0;
         v          <= '0;
         settle_cnt <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= INIT;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  err_count <= '0;
                  fail_idx  <= '0;
                  v         <= '0;
                  en        <= 1'b1;
                  j         <= 1'b0;
                  k         <= 1'b1;
               end
            end
            INIT: begin
               exp_q      <= 1'b0;
               {en, j, k} <= 3'b000;
               settle_cnt <= SETTLE_LOAD;
               state      <= INIT_WAIT;
            end
            INIT_WAIT: begin
               if (settle_cnt == 4'd0) begin
                  {en, j, k} <= drive_vec;
                  state      <= DRIVE;
               end else begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            DRIVE: begin
               exp_q      <= exp_next;
               {en, j, k} <= 3'b000;
               settle_cnt <= SETTLE_LOAD;
               state      <= WAIT;
            end
            WAIT: begin
               if (settle_cnt == 4'd0) begin
                  state <= CHECK;
               end else begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            CHECK: begin
               err_count <= err_inc;
               // err_count still zero means this is the first failing vector of the run.
               if (mismatch && err_count == '0) begin
                  fail_idx <= v;
               end
               if (v == V_LAST) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_inc == '0);
               end else begin
                  v          <= v + VW'(1);
                  {en, j, k} <= drive_vec;
                  state      <= DRIVE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jk_stim_checker.sv
// Bench for jk_stim_checker: behavioural JK flip-flop with injectable faults, timeline model, directed runs.
module tb_jk_stim_checker;

   localparam int         N      = 8;
   localparam int         S      = 1;
   localparam logic [7:0] SEED_P = 8'hA5;
   localparam int         DONE_PH = 1 + S + N * (2 + S);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       q, q_bar;
   logic       j, k, en, busy, done, pass;
   logic [3:0] err_count;
   logic [2:0] fail_idx;

   int  n_cmp = 0;
   int  n_bad = 0;
   int  fault_mode = 0;
   int  ph = -1;
   bit  chk_en = 1'b0;
   bit  run_mis [N];
   logic ff = 1'b0;

   jk_stim_checker #(.NUM_VEC(N), .SETTLE_CYC(S), .SEED(SEED_P)) dut (
      .clk(clk), .rst(rst), .start(start), .q(q), .q_bar(q_bar),
      .j(j), .k(k), .en(en), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_idx(fail_idx)
   );

   always #5 clk = ~clk;

   // Flip-flop under test with optional faults.
   always @(posedge clk) begin
      if (en) begin
         if (j && k)  ff <= ~ff;
         else if (j)  ff <= 1'b1;
         else if (k)  ff <= 1'b0;
      end
   end
   assign q     = (fault_mode == 1) ? 1'b0 : (fault_mode == 2) ? 1'b1 : ff;
   assign q_bar = (fault_mode == 3) ? q : ~q;

   task automatic check(input string nm, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp_v);
      end
   endtask

   function automatic logic [2:0] vec_of(input int i);
      logic [2:0] r;
`ifdef JKC_LFSR_EN
      int st;
      st = int'(SEED_P);
      for (int s = 0; s < i; s++) begin
         st = ((st * 2) % 256) + (((st >> 7) + (st >> 5) + (st >> 4) + (st >> 3)) % 2);
      end
      r = 3'(st % 8);
`else
      r = {((i / 4) % 2 == 0), ((i / 2) % 2 == 1), (i % 2 == 1)};
`endif
      return r;
   endfunction

   function automatic bit golden_after(input int i);
      bit gq = 1'b0;
      logic [2:0] vv;
      for (int s = 0; s <= i; s++) begin
         vv = vec_of(s);
         if (vv[2]) begin
            if (vv[1] && vv[0]) gq = ~gq;
            else if (vv[1])     gq = 1'b1;
            else if (vv[0])     gq = 1'b0;
         end
      end
      return gq;
   endfunction

   function automatic bit mis_of(input int mode, input int i);
      bit eq, oq, oqb;
      eq  = golden_after(i);
      oq  = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : eq;
      oqb = (mode == 3) ? oq : ~oq;
      return (oq != eq) || (oqb != ~eq);
   endfunction

   // Timeline model: ph counts edges since the accepting start edge.
   always @(posedge clk) begin
      if (rst) begin
         ph <= -1;
      end else if (start && (ph < 0 || ph >= DONE_PH)) begin
         ph <= 0;
         for (int i = 0; i < N; i++) run_mis[i] <= mis_of(fault_mode, i);
      end else if (ph >= 0 && ph < 100000) begin
         ph <= ph + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [2:0] m_drv;
         int m_err, m_fail, n_chk, r;
         bit m_busy, m_done, found;
         m_drv = 3'b000;
         m_err = 0; m_fail = 0; n_chk = 0; found = 1'b0;
         m_busy = (ph >= 0) && (ph < DONE_PH);
         m_done = (ph >= DONE_PH);
         if (ph == 0) m_drv = 3'b101;
         r = ph - 1 - S;
         if (ph >= 0 && r >= 0 && (r / (2 + S)) < N && (r % (2 + S)) == 0) m_drv = vec_of(r / (2 + S));
         if (ph >= 0) begin
            for (int i = 0; i < N; i++) if (1 + S + (i + 1) * (2 + S) <= ph) n_chk++;
            for (int i = 0; i < n_chk; i++) begin
               if (run_mis[i]) begin
                  m_err++;
                  if (!found) begin m_fail = i; found = 1'b1; end
               end
            end
         end
         check("en", int'(en), int'(m_drv[2]));
         check("j", int'(j), int'(m_drv[1]));
         check("k", int'(k), int'(m_drv[0]));
         check("busy", int'(busy), int'(m_busy));
         check("done", int'(done), int'(m_done));
         check("pass", int'(pass), int'(m_done && m_err == 0));
         check("err_count", int'(err_count), m_err);
         check("fail_idx", int'(fail_idx), m_fail);
      end
   end

   task automatic check_reset_vals(input string nm);
      check({nm, "_busy"}, int'(busy), 0);
      check({nm, "_done"}, int'(done), 0);
      check({nm, "_pass"}, int'(pass), 0);
      check({nm, "_err"}, int'(err_count), 0);
      check({nm, "_fidx"}, int'(fail_idx), 0);
      check({nm, "_enjk"}, int'({en, j, k}), 0);
   endtask

   task automatic run_test(input string nm, input int mode, input int restart_at, input int abort_at,
                           input int exp_err, input int exp_fail, input int exp_pass);
      int cyc;
      fault_mode = mode;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cyc = 0;
      while (!done && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         start = (cyc == restart_at);
         if (cyc == abort_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check_reset_vals({nm, "_abort"});
            return;
         end
      end
      if (cyc >= 100) check({nm, "_timeout"}, cyc, DONE_PH);
      check({nm, "_latency"}, cyc, 26);
      check({nm, "_err"}, int'(err_count), exp_err);
      check({nm, "_fidx"}, int'(fail_idx), exp_fail);
      check({nm, "_pass"}, int'(pass), exp_pass);
      repeat (3) @(posedge clk);
      #1 check({nm, "_hold_done"}, int'(done), 1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 check_reset_vals("reset");
      rst = 1'b0;
      chk_en = 1'b1;
`ifndef JKC_LFSR_EN
      begin
         bit exp_tab [N];
         exp_tab = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
         for (int i = 0; i < N; i++) check($sformatf("golden_q%0d", i), int'(golden_after(i)), int'(exp_tab[i]));
      end
`endif
      run_test("good", 0, -1, -1, 0, 0, 1);
`ifndef JKC_LFSR_EN
      run_test("q_sa0", 1, -1, -1, 1, 2, 0);
      run_test("q_sa1", 2, -1, -1, 7, 0, 0);
`endif
      run_test("qb_eq_q", 3, -1, -1, 8, 0, 0);
      run_test("restart_busy", 0, 10, -1, 0, 0, 1);
      run_test("abort_v4", 0, -1, 15, 0, 0, 0);
      run_test("after_abort", 0, -1, -1, 0, 0, 1);
      // start coinciding with rst must not launch a run
      @(posedge clk); #1 begin rst = 1'b1; start = 1'b1; end
      @(posedge clk); #1 begin rst = 1'b0; start = 1'b0; end
      check_reset_vals("rst_wins");
      repeat (2) @(posedge clk);
      #1 check("rst_wins_busy_later", int'(busy), 0);
      run_test("final", 0, -1, -1, 0, 0, 1);
      @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/jk_stim_checker.md
Name: jk_stim_checker

Overview:
- Synthesizable initiator and checker for the clocked JK flip-flop.
- Drives j/k/en stimulus vectors into a JK flip-flop under test and tracks the expected state with an internal golden JK model.
- Samples q/q_bar after a settle window and counts mismatches.
- Sits beside the flip-flop as its on-chip self-test driver; it is the driving and checking end of the j/k/en ↔ q/q_bar interface.

Parameters:
- NUM_VEC, 8, number of stimulus vectors per run (2..256).
- SETTLE_CYC, 1, idle cycles between driving a vector and sampling q/q_bar (1..15).
- SEED, 8'hA5, LFSR seed; used only with JKC_LFSR_EN; must be non-zero.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; ignored while busy.
- q  input  1  flip-flop output under test.
- q_bar  input  1  complementary flip-flop output under test.
- j  output  1  J drive, registered.
- k  output  1  K drive, registered.
- en  output  1  enable drive, registered.
- busy  output  1  high from start acceptance until entry to DONE.
- done  output  1  high in DONE; held until the next accepted start or rst.
- pass  output  1  done && err_count==0.
- err_count  output  $clog2(NUM_VEC+1)  number of failing vectors; saturates at NUM_VEC.
- fail_idx  output  $clog2(NUM_VEC)  index of the first failing vector; 0 if none.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; j=0, k=0, en=0; busy=0, done=0, pass=0, err_count=0, fail_idx=0; exp=0; vector counter v=0.
- rst mid-run aborts immediately to these values; no partial results are kept.
- The expected DUT behaviour is a rising-edge JK flip-flop:
  - en=1, jk=00: hold.
  - en=1, jk=01: q=0.
  - en=1, jk=10: q=1.
  - en=1, jk=11: toggle.
  - en=0: hold.
- FSM states: IDLE, INIT, INIT_WAIT, DRIVE, WAIT, CHECK, DONE.
- IDLE / DONE: on start=1, go to INIT. Also: busy=1, done=0, err_count=0, fail_idx=0, v=0.
- INIT (1 cycle): drive en=1, j=0, k=1 to force a known state; exp<=0. Then go to INIT_WAIT. INIT is not checked.
- INIT_WAIT (SETTLE_CYC cycles): drive en=0, j=0, k=0. Then go to DRIVE.
- DRIVE (1 cycle): drive vector v. With default pattern, {en,j,k} = {~v[2], v[1], v[0]}. At the edge leaving DRIVE, exp is updated per the JK rules using the driven vector. Then go to WAIT.
- WAIT (SETTLE_CYC cycles): drive en=0, j=0, k=0, so toggle vectors act exactly once. A settle counter counts the cycles. Then go to CHECK.
- CHECK (1 cycle): mismatch = (q!=exp) || (q_bar!=~exp).
  - On mismatch: err_count increments (saturating).
  - On the first mismatch of the run: fail_idx<=v.
  - If v==NUM_VEC-1: go to DONE, busy<=0, done<=1. Otherwise v<=v+1 and go to DRIVE.
- Latency: done is high 1+SETTLE_CYC+NUM_VEC*(2+SETTLE_CYC) cycles after the start edge. Default is 26.
- start while busy: ignored, no effect.
- start in the same cycle as rst: rst wins.
- q/q_bar X or Z at CHECK: counted as a mismatch (use case-inequality in simulation only).
- Default expected q per vector 0..7: 0, 0, 1, 0, 0, 0, 0, 0.

Optional Feature:
- Macro: JKC_LFSR_EN.
- Defined:
  - The vector source is an 8-bit Fibonacci LFSR with taps 8, 6, 5, 4, loaded with SEED on accepted start.
  - It advances once per DRIVE exit.
  - {en,j,k} = lfsr[2:0].
  - The golden model is unchanged.
- Undefined: the counting pattern above; no LFSR logic is synthesized.

Test Plan:
- Behavioural correct JK DUT attached, default params, start pulse: done high 26 cycles later, err_count=0, pass=1, fail_idx=0.
- DUT q stuck at 0, q_bar=~q: err_count=1, fail_idx=2, pass=0.
- DUT q stuck at 1, q_bar=~q: err_count=7, fail_idx=0.
- Correct q, q_bar tied to q: err_count=8, fail_idx=0.
- rst asserted during vector 4 WAIT: next cycle all outputs at reset values. A later start with a correct DUT gives pass=1.
- start pulsed again while busy: run length and results unchanged.
- JKC_LFSR_EN, SEED=8'hA5, correct DUT: pass=1. Per-vector {en,j,k} matches the LFSR reference model in the bench.
